xil_bram_rd_stream: RTL and testbench
=====================================

XIL_BRAM_RD_STREAM -- requirements
Module: xil_bram_rd_stream

Interface
REQ-001 SHALL have parameter ADR, default 10: RAM address width.
REQ-002 SHALL have parameter DAT, default 18: RAM data width.
REQ-003 SHALL have parameter DEL, default 1: RAM read latency in cycles (ren to rda), legal 1..3.
REQ-004 SHALL have parameter SKD, default 4: skid buffer depth in words, legal SKD >= DEL+2.
REQ-005 SHALL have port rclk, input, 1: the single clock.
REQ-006 SHALL have port rrst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port cmd_vld, input, 1: read burst request valid.
REQ-008 SHALL have port cmd_rdy, output, 1: request accepted when cmd_vld & cmd_rdy.
REQ-009 SHALL have port cmd_adr, input, ADR: burst start address.
REQ-010 SHALL have port cmd_len, input, ADR: burst length minus one (0 = 1 word, all-ones = 2^ADR words).
REQ-011 SHALL have port ren, output, 1: RAM read enable.
REQ-012 SHALL have port rad, output, ADR: RAM read address.
REQ-013 SHALL have port rda, input, DAT: RAM read data, valid DEL cycles after ren.
REQ-014 SHALL have port out_vld, output, 1: stream word valid.
REQ-015 SHALL have port out_rdy, input, 1: stream sink ready; transfer = out_vld & out_rdy.
REQ-016 SHALL have port out_dat, output, DAT: stream word.
REQ-017 SHALL have port out_last, output, 1: marks final word of burst.
REQ-018 SHALL have port busy, output, 1: burst in progress or words still held.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-020 SHALL assert cmd_rdy only in IDLE; acceptance moves IDLE->RUN, loads address counter = cmd_adr, remaining counter = cmd_len.
REQ-021 SHALL in RUN assert ren with rad = address counter when in-flight reads plus buffered words < SKD; each issue increments address (mod 2^ADR, wrap 2^ADR-1 -> 0) and decrements remaining.
REQ-022 SHALL move RUN->DRAIN in the cycle the read with remaining = 0 is issued; DRAIN->IDLE when no reads are in flight and the skid buffer is empty after the last transfer.
REQ-023 SHALL track in-flight reads with a DEL-stage valid/last shift pipeline and write rda into the skid buffer exactly DEL cycles after the matching ren.
REQ-024 SHALL never overflow the skid buffer; the credit check in REQ-021 guarantees space for every in-flight read.
REQ-025 SHALL present skid buffer head on out_dat/out_last with out_vld = buffer non-empty; simultaneous write and read in one cycle SHALL both take effect.
REQ-026 SHALL deliver first out_vld at cycle t+DEL+2 after acceptance at cycle t, and sustain one word/cycle while out_rdy = 1.
REQ-027 SHALL hold out_dat/out_last stable while out_vld = 1 and out_rdy = 0.
REQ-028 SHALL assert out_last on exactly one word per burst, the word read from address cmd_adr+cmd_len (mod 2^ADR).
REQ-029 SHALL drive busy = (state != IDLE).

Reset
REQ-030 SHALL on rrst asynchronously force: state IDLE, cmd_rdy 1 after reset deassertion, ren 0, rad 0, out_vld 0, out_dat 0, out_last 0, busy 0, pipeline and skid buffer empty.
REQ-031 SHALL on reset mid-burst discard all in-flight and buffered words; no stale word SHALL appear after reset release.

Configuration
REQ-032 SHALL compile, with macro XIL_BRAM_RD_STREAM_PARITY_EN defined, an output port out_perr (1 bit) flagging, with out_vld, a word whose even parity over all DAT bits (MSB is the parity bit) fails; out_perr SHALL reset to 0.
REQ-033 SHALL without XIL_BRAM_RD_STREAM_PARITY_EN omit out_perr and all parity logic, data passed unchecked.

Structure
REQ-034 SHALL place the FSM state enum (IDLE/RUN/DRAIN) and parameter-legality constants in package xil_bram_rd_stream_pkg.
REQ-035 SHALL implement the skid buffer as sub-module xil_bram_rd_skid (SKD x (DAT+1) register FIFO with count output).

Verification
REQ-036 SHALL test DEL=1, SKD=4: cmd_adr=5, cmd_len=3, out_rdy=1 -> ren on 4 consecutive cycles, rad 5,6,7,8; 4 back-to-back words, first at t+3, out_last on word from 8.
REQ-037 SHALL test ADR=4: cmd_adr=14, cmd_len=3 -> rad 14,15,0,1; out_last on address 1.
REQ-038 SHALL test out_rdy=0 for 10 cycles during 8-word burst -> ren stops after 4 outstanding words, no lost/duplicated data, order preserved.
REQ-039 SHALL test cmd_len=0 -> single word with out_last=1, cmd_rdy high again after DRAIN empties.
REQ-040 SHALL test rrst pulse mid-burst -> all outputs zero immediately; next burst returns only new data.
REQ-041 SHALL test with XIL_BRAM_RD_STREAM_PARITY_EN one corrupted RAM word -> out_perr=1 on that word only.

Source files
------------

// File: rtl/xil_bram_rd_stream_pkg.sv
// Shared types and parameter-legality limits for the BRAM read-burst streamer.
package xil_bram_rd_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEL_MIN    = 1;
    localparam int DEL_MAX    = 3;
    localparam int SKD_MARGIN = 2;

    function automatic bit params_legal(input int del, input int skd);
        return (del >= DEL_MIN) && (del <= DEL_MAX) && (skd >= del + SKD_MARGIN);
    endfunction

endpackage

// File: rtl/xil_bram_rd_skid.sv
// Register FIFO of D words with occupancy count; head is visible combinationally.
// Push and pop in the same cycle both take effect; the writer guarantees space.
module xil_bram_rd_skid #(
    parameter  int W  = 19,
    parameter  int D  = 4,
    localparam int CW = $clog2(D + 1),
    localparam int PW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_vld_i,
    input  logic [W-1:0]  wr_dat_i,
    input  logic          rd_rdy_i,
    output logic          rd_vld_o,
    output logic [W-1:0]  rd_dat_o,
    output logic [CW-1:0] cnt_o
);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_vld_o = (cnt_q != '0);
    assign cnt_o    = cnt_q;
    // Empty buffer drives zeros so nothing stale is visible after reset or drain.
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        pop      = rd_vld_o & rd_rdy_i;
        wr_ptr_d = wr_vld_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr_vld_i) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (wr_vld_i) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
            end
        end
    end

endmodule

// File: rtl/xil_bram_rd_stream.sv
// Streams a BRAM burst as valid/ready words; first word DEL+2 cycles after accept, then 1/cycle.
// Reads are credit-limited to skid space. Macro XIL_BRAM_RD_STREAM_PARITY_EN adds out_perr.
module xil_bram_rd_stream
    import xil_bram_rd_stream_pkg::*;
#(
    parameter int ADR = 10,
    parameter int DAT = 18,
    parameter int DEL = 1,
    parameter int SKD = 4
) (
    input  logic           rclk,
    input  logic           rrst,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  logic [ADR-1:0] cmd_adr,
    input  logic [ADR-1:0] cmd_len,
    output logic           ren,
    output logic [ADR-1:0] rad,
    input  logic [DAT-1:0] rda,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [DAT-1:0] out_dat,
    output logic           out_last,
`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
    output logic           out_perr,
`endif
    output logic           busy
);

    localparam int CW = $clog2(SKD + 1);

    if (!params_legal(DEL, SKD)) begin : g_param_check
        $error("xil_bram_rd_stream: DEL must be 1..3 and SKD >= DEL+2");
    end

    state_t         state_q, state_d;
    logic [ADR-1:0] adr_q, adr_d;
    logic [ADR-1:0] rem_q, rem_d;
    logic [DEL-1:0] pipe_vld_q, pipe_last_q;
    logic [1:0]     inflight;
    logic [CW-1:0]  skid_cnt;
    logic [DAT:0]   skid_dat;
    logic           credit_ok;
    logic           ren_c;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DEL; i++) begin
            inflight = inflight + 2'(pipe_vld_q[i]);
        end
    end

    // Every issued read must already own a skid slot when its data lands.
    assign credit_ok = (int'(inflight) + int'(skid_cnt)) < SKD;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        ren_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    state_d = RUN;
                    adr_d   = cmd_adr;
                    rem_d   = cmd_len;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    ren_c = 1'b1;
                    adr_d = adr_q + ADR'(1);
                    rem_d = rem_q - ADR'(1);
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight == '0 && skid_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            rem_q       <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q        <= state_d;
            adr_q          <= adr_d;
            rem_q          <= rem_d;
            pipe_vld_q[0]  <= ren_c;
            pipe_last_q[0] <= ren_c && (rem_q == '0);
            for (int i = 1; i < DEL; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    xil_bram_rd_skid #(
        .W (DAT + 1),
        .D (SKD)
    ) u_skid (
        .clk_i    (rclk),
        .rst_i    (rrst),
        .wr_vld_i (pipe_vld_q[DEL-1]),
        .wr_dat_i ({pipe_last_q[DEL-1], rda}),
        .rd_rdy_i (out_rdy),
        .rd_vld_o (out_vld),
        .rd_dat_o (skid_dat),
        .cnt_o    (skid_cnt)
    );

    assign cmd_rdy  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign ren      = ren_c;
    assign rad      = adr_q;
    assign out_dat  = skid_dat[DAT-1:0];
    assign out_last = skid_dat[DAT];

`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
    // Stored words carry even parity with the MSB as parity bit.
    assign out_perr = out_vld & (^out_dat);
`endif

endmodule

// File: tb/tb_xil_bram_rd_stream.sv
// Randomized bench for xil_bram_rd_stream with a behavioural RAM and burst model.
module tb_xil_bram_rd_stream;

    localparam int ADR    = 4;
    localparam int DAT    = 18;
    localparam int DEL    = 1;
    localparam int SKD    = 4;
    localparam int NW     = 1 << ADR;
    localparam int BUDGET = 300;

    logic           rclk, rrst, cmd_vld, cmd_rdy, ren, out_vld, out_rdy, out_last, busy;
    logic [ADR-1:0] cmd_adr, cmd_len, rad;
    logic [DAT-1:0] rda, out_dat;
`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
    logic           out_perr;
`endif

    int checks = 0;
    int passes = 0;

    logic [DAT-1:0] ram [NW];
    logic [DAT-1:0] obs_dat[$];
    bit             obs_last[$];
    bit             obs_perr[$];
    int             obs_rad[$];
    int             obs_rcyc[$];
    int             obs_tcyc[$];
    int             first_cyc, max_outst;
    bit             timeout, end_rdy;

    xil_bram_rd_stream #(.ADR(ADR), .DAT(DAT), .DEL(DEL), .SKD(SKD)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_adr  (cmd_adr),
        .cmd_len  (cmd_len),
        .ren      (ren),
        .rad      (rad),
        .rda      (rda),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_dat  (out_dat),
        .out_last (out_last),
`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
        .out_perr (out_perr),
`endif
        .busy     (busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // One-cycle BRAM read port.
    always @(posedge rclk) begin
        if (ren) rda <= ram[rad];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_ram(input bit par);
        for (int i = 0; i < NW; i++) begin
            logic [31:0] w;
            w = $urandom;
            ram[i] = w[DAT-1:0];
            if (par) ram[i][DAT-1] = ^ram[i][DAT-2:0];
        end
    endtask

    function automatic logic [DAT-1:0] exp_word(input int a, input int i);
        return ram[(a + i) % NW];
    endfunction

    // Runs one burst and records what the DUT did; cycle 0 is the handshake cycle.
    task automatic run_burst(input logic [ADR-1:0] a, input logic [ADR-1:0] l,
                             input int s0, input int sl, input bit rnd);
        int cyc, issued, taken;
        obs_dat.delete(); obs_last.delete(); obs_perr.delete();
        obs_rad.delete(); obs_rcyc.delete(); obs_tcyc.delete();
        first_cyc = -1; max_outst = 0; timeout = 1'b0; end_rdy = 1'b0;
        issued = 0; taken = 0;
        @(posedge rclk); #1;
        cmd_vld = 1'b1; cmd_adr = a; cmd_len = l; out_rdy = 1'b1;
        @(negedge rclk);
        for (cyc = 1; cyc <= BUDGET; cyc++) begin
            @(posedge rclk); #1;
            cmd_vld = 1'b0;
            if (cyc >= s0 && cyc < s0 + sl) out_rdy = 1'b0;
            else if (rnd)                   out_rdy = ($urandom_range(0, 3) != 0);
            else                            out_rdy = 1'b1;
            @(negedge rclk);
            if (ren) begin
                obs_rad.push_back(int'(rad)); obs_rcyc.push_back(cyc); issued++;
            end
            if (out_vld && first_cyc < 0) first_cyc = cyc;
            if (out_vld && out_rdy) begin
                obs_dat.push_back(out_dat); obs_last.push_back(out_last); obs_tcyc.push_back(cyc);
`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
                obs_perr.push_back(out_perr);
`endif
                taken++;
            end
            if (issued - taken > max_outst) max_outst = issued - taken;
            if (!busy) begin
                end_rdy = cmd_rdy;
                break;
            end
        end
        if (cyc > BUDGET) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rrst = 1'b1; cmd_vld = 1'b0; cmd_adr = '0; cmd_len = '0; out_rdy = 1'b0;
        #2;
        checks++; if (ren !== 1'b0)     $display("FAIL reset_ren: got %b want 0", ren);           else passes++;
        checks++; if (rad !== '0)       $display("FAIL reset_rad: got %0d want 0", rad);          else passes++;
        checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b want 0", out_vld);   else passes++;
        checks++; if (out_dat !== '0)   $display("FAIL reset_out_dat: got %h want 0", out_dat);   else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else passes++;
        checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);         else passes++;
        @(posedge rclk); #1; rrst = 1'b0;
        @(negedge rclk);
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL reset_cmd_rdy: got %b want 1", cmd_rdy);   else passes++;
    endtask

    task automatic test_basic();
        fill_ram(1'b0);
        run_burst(4'd5, 4'd3, 0, 0, 1'b0);
        checks++; if (timeout) $display("FAIL basic_timeout: still busy after %0d cycles", BUDGET); else passes++;
        checks++; if (obs_rad.size() != 4) $display("FAIL basic_ren_count: got %0d want 4", obs_rad.size()); else passes++;
        for (int i = 0; i < obs_rad.size() && i < 4; i++) begin
            checks++;
            if (obs_rad[i] != 5 + i || obs_rcyc[i] != 1 + i)
                $display("FAIL basic_ren[%0d]: rad %0d at cycle %0d, want rad %0d at cycle %0d", i, obs_rad[i], obs_rcyc[i], 5 + i, 1 + i);
            else passes++;
        end
        checks++; if (first_cyc != 3) $display("FAIL basic_first_vld: cycle %0d want 3", first_cyc); else passes++;
        checks++; if (obs_dat.size() != 4) $display("FAIL basic_word_count: got %0d want 4", obs_dat.size()); else passes++;
        for (int i = 0; i < obs_dat.size() && i < 4; i++) begin
            checks++;
            if (obs_dat[i] !== exp_word(5, i) || obs_last[i] != (i == 3) || obs_tcyc[i] != 3 + i)
                $display("FAIL basic_word[%0d]: dat %h last %0d cyc %0d, want dat %h last %0d cyc %0d",
                         i, obs_dat[i], obs_last[i], obs_tcyc[i], exp_word(5, i), (i == 3), 3 + i);
            else passes++;
        end
        checks++; if (end_rdy !== 1'b1) $display("FAIL basic_cmd_rdy_after: got %b want 1", end_rdy); else passes++;
    endtask

    task automatic test_wrap();
        int exp_rad [4] = '{14, 15, 0, 1};
        fill_ram(1'b0);
        run_burst(4'd14, 4'd3, 0, 0, 1'b0);
        checks++; if (timeout || obs_rad.size() != 4) $display("FAIL wrap_ren_count: got %0d timeout %0d want 4", obs_rad.size(), timeout); else passes++;
        for (int i = 0; i < obs_rad.size() && i < 4; i++) begin
            checks++; if (obs_rad[i] != exp_rad[i]) $display("FAIL wrap_rad[%0d]: got %0d want %0d", i, obs_rad[i], exp_rad[i]); else passes++;
        end
        checks++; if (obs_dat.size() != 4) $display("FAIL wrap_word_count: got %0d want 4", obs_dat.size()); else passes++;
        for (int i = 0; i < obs_dat.size() && i < 4; i++) begin
            checks++;
            if (obs_dat[i] !== ram[exp_rad[i]] || obs_last[i] != (exp_rad[i] == 1))
                $display("FAIL wrap_word[%0d]: dat %h last %0d want dat %h last %0d", i, obs_dat[i], obs_last[i], ram[exp_rad[i]], (exp_rad[i] == 1));
            else passes++;
        end
    endtask

    task automatic test_stall();
        fill_ram(1'b0);
        run_burst(4'd2, 4'd7, 2, 10, 1'b0);
        checks++; if (timeout) $display("FAIL stall_timeout: still busy after %0d cycles", BUDGET); else passes++;
        checks++; if (max_outst != SKD) $display("FAIL stall_outstanding: peak %0d want %0d", max_outst, SKD); else passes++;
        checks++; if (obs_rad.size() != 8) $display("FAIL stall_ren_count: got %0d want 8", obs_rad.size()); else passes++;
        checks++; if (obs_dat.size() != 8) $display("FAIL stall_word_count: got %0d want 8", obs_dat.size()); else passes++;
        for (int i = 0; i < obs_dat.size() && i < 8; i++) begin
            checks++;
            if (obs_dat[i] !== exp_word(2, i) || obs_last[i] != (i == 7))
                $display("FAIL stall_word[%0d]: dat %h last %0d want dat %h last %0d", i, obs_dat[i], obs_last[i], exp_word(2, i), (i == 7));
            else passes++;
        end
    endtask

    task automatic test_single();
        fill_ram(1'b0);
        run_burst(4'd9, 4'd0, 0, 0, 1'b0);
        checks++; if (obs_rad.size() != 1) $display("FAIL single_ren_count: got %0d want 1", obs_rad.size()); else passes++;
        checks++;
        if (obs_dat.size() != 1 || obs_dat[0] !== ram[9] || obs_last[0] != 1'b1)
            $display("FAIL single_word: count %0d dat %h last %0d want count 1 dat %h last 1",
                     obs_dat.size(), (obs_dat.size() > 0) ? obs_dat[0] : '0, (obs_last.size() > 0) ? obs_last[0] : 1'b0, ram[9]);
        else passes++;
        checks++; if (timeout || end_rdy !== 1'b1) $display("FAIL single_cmd_rdy_after: got %b timeout %0d want 1", end_rdy, timeout); else passes++;
    endtask

    task automatic test_random();
        for (int b = 0; b < 12; b++) begin
            int a, l, nbad;
            a = $urandom_range(0, NW - 1);
            l = $urandom_range(0, NW - 1);
            fill_ram(1'b0);
            run_burst(ADR'(a), ADR'(l), $urandom_range(1, 8), $urandom_range(0, 12), 1'b1);
            checks++;
            if (timeout || obs_dat.size() != l + 1 || obs_rad.size() != l + 1)
                $display("FAIL rand%0d_counts: words %0d reads %0d timeout %0d want %0d", b, obs_dat.size(), obs_rad.size(), timeout, l + 1);
            else passes++;
            nbad = 0;
            for (int i = 0; i < obs_dat.size() && i <= l; i++)
                if (obs_dat[i] !== exp_word(a, i) || obs_last[i] != (i == l)) nbad++;
            for (int i = 0; i < obs_rad.size() && i <= l; i++)
                if (obs_rad[i] != (a + i) % NW) nbad++;
            checks++; if (nbad != 0) $display("FAIL rand%0d_content: %0d wrong items of burst adr %0d len %0d", b, nbad, a, l); else passes++;
            checks++; if (max_outst > SKD) $display("FAIL rand%0d_outstanding: peak %0d limit %0d", b, max_outst, SKD); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        fill_ram(1'b0);
        @(posedge rclk); #1;
        cmd_vld = 1'b1; cmd_adr = '0; cmd_len = 4'd15; out_rdy = 1'b0;
        @(posedge rclk); #1;
        cmd_vld = 1'b0;
        repeat (4) @(posedge rclk);
        #3;
        checks++; if (busy !== 1'b1 || out_vld !== 1'b1) $display("FAIL rstmid_pre: busy %b out_vld %b want 1 1", busy, out_vld); else passes++;
        rrst = 1'b1;
        #1;
        checks++;
        if ({ren, out_vld, out_last, busy} !== 4'b0 || rad !== '0 || out_dat !== '0)
            $display("FAIL rstmid_outputs: ren %b out_vld %b out_last %b busy %b rad %0d out_dat %h want all 0",
                     ren, out_vld, out_last, busy, rad, out_dat);
        else passes++;
        fill_ram(1'b0);
        repeat (2) @(posedge rclk);
        #1; rrst = 1'b0; out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            checks++; if (out_vld !== 1'b0) $display("FAIL rstmid_idle_vld[%0d]: got %b want 0", c, out_vld); else passes++;
        end
        run_burst(4'd0, 4'd7, 0, 0, 1'b0);
        checks++; if (obs_dat.size() != 8) $display("FAIL rstmid_word_count: got %0d want 8", obs_dat.size()); else passes++;
        for (int i = 0; i < obs_dat.size() && i < 8; i++) begin
            checks++;
            if (obs_dat[i] !== exp_word(0, i) || obs_last[i] != (i == 7))
                $display("FAIL rstmid_word[%0d]: dat %h last %0d want dat %h last %0d", i, obs_dat[i], obs_last[i], exp_word(0, i), (i == 7));
            else passes++;
        end
    endtask

`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
    task automatic test_parity();
        fill_ram(1'b1);
        ram[3][0] = ~ram[3][0];
        run_burst(4'd0, 4'd7, 3, 4, 1'b0);
        checks++; if (obs_perr.size() != 8) $display("FAIL parity_count: got %0d want 8", obs_perr.size()); else passes++;
        for (int i = 0; i < obs_perr.size() && i < 8; i++) begin
            checks++; if (obs_perr[i] != (i == 3)) $display("FAIL parity_perr[%0d]: got %0d want %0d", i, obs_perr[i], (i == 3)); else passes++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_single();
        test_random();
        test_reset_mid();
`ifdef XIL_BRAM_RD_STREAM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
